// File: rtl/quant_pkg.sv
// Shared types and constants for the FP32-to-INT8 quantize stream controller.
package quant_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] FP32_ONE = 32'h3F80_0000;

  typedef struct packed {
    logic [31:0] scale;
    logic [7:0]  zp;
    logic        asym;
  } tbl_entry_t;

  localparam tbl_entry_t TBL_RESET = '{scale: FP32_ONE, zp: 8'd0, asym: 1'b0};

endpackage

// File: rtl/quant_out_fifo.sv
// Synchronous FIFO holding quantized results; read data is combinational from the head slot.
// Push into a full FIFO and pop from an empty one are ignored.
module quant_out_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed behind a nonzero count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/quant_stream_ctrl.sv
// Job sequencer for the quantize pipeline: issues FP32 elements with per-channel parameters
// and collects results in an output FIFO. Issue is credit-gated so in-flight work always fits.
module quant_stream_ctrl #(
  parameter int CH_W       = 4,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_addr,
  input  logic [31:0]       cfg_scale,
  input  logic [7:0]        cfg_zp,
  input  logic              cfg_asym,
  input  logic              start,
  input  logic [CH_W-1:0]   num_ch,
  input  logic [LEN_W-1:0]  num_elem,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  sat_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              pq_ena,
  output logic [31:0]       pq_fp_in,
  output logic [31:0]       pq_scale,
  output logic [7:0]        pq_zp,
  output logic              pq_use_asym,
  input  logic [7:0]        pq_q_out,
  input  logic              pq_sat,
  input  logic              pq_out_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_sat,
  output logic              out_last
);

  import quant_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TBL_N = 2**CH_W;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, num_ch_q, num_ch_d;
  logic [LEN_W-1:0]  num_elem_q, num_elem_d, issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]  pop_cnt_q, pop_cnt_d, sat_cnt_q, sat_cnt_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  tbl_entry_t        tbl_q [TBL_N];
  tbl_entry_t        tbl_d [TBL_N];

  tbl_entry_t        cur;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic [8:0]        fifo_dat;
  logic              issue, res_acc, pop;
  logic [LEN_W-1:0]  last_idx;

  assign cur      = tbl_q[ch_q];
  assign last_idx = num_elem_q - LEN_W'(1);

  // Credits: every issued element owns a FIFO slot until it is popped.
  assign in_ready = (state_q == ST_RUN) &&
                    (({1'b0, fifo_cnt} + {1'b0, inflight_q}) < (CNT_W+1)'(FIFO_DEPTH));
  assign issue    = in_valid && in_ready;
  // Results arriving outside an active job are stale and dropped.
  assign res_acc  = pq_out_valid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  assign pq_ena      = issue;
  assign pq_fp_in    = issue ? in_data   : '0;
  assign pq_scale    = issue ? cur.scale : '0;
  assign pq_zp       = issue ? cur.zp    : '0;
  assign pq_use_asym = issue && cur.asym;

  assign out_data  = out_valid ? fifo_dat[8:1] : '0;
  assign out_sat   = out_valid && fifo_dat[0];
  assign out_last  = out_valid && (pop_cnt_q == last_idx);

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign sat_count = sat_cnt_q;

  quant_out_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (res_acc),
    .push_dat ({pq_q_out, pq_sat}),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    num_ch_d    = num_ch_q;
    num_elem_d  = num_elem_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    sat_cnt_d   = sat_cnt_q;
    inflight_d  = inflight_q;
    tbl_d       = tbl_q;

    if (pop) pop_cnt_d = pop_cnt_q + LEN_W'(1);
    if (res_acc && pq_sat && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + LEN_W'(1);
    case ({issue, res_acc})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (cfg_we) tbl_d[cfg_addr] = '{scale: cfg_scale, zp: cfg_zp, asym: cfg_asym};
        if (start) begin
          if (num_elem == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_RUN;
            num_ch_d    = (num_ch == '0) ? CH_W'(1) : num_ch;
            num_elem_d  = num_elem;
            ch_d        = '0;
            issue_cnt_d = '0;
            pop_cnt_d   = '0;
            sat_cnt_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          ch_d        = (ch_q == num_ch_q - CH_W'(1)) ? '0 : ch_q + CH_W'(1);
          issue_cnt_d = issue_cnt_q + LEN_W'(1);
          if (issue_cnt_q == last_idx) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (pop_cnt_q == last_idx)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      num_ch_q    <= '0;
      num_elem_q  <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      sat_cnt_q   <= '0;
      inflight_q  <= '0;
      for (int i = 0; i < TBL_N; i++) tbl_q[i] <= TBL_RESET;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      num_ch_q    <= num_ch_d;
      num_elem_q  <= num_elem_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      sat_cnt_q   <= sat_cnt_d;
      inflight_q  <= inflight_d;
      tbl_q       <= tbl_d;
    end
  end

endmodule
